// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// memory command words and the misalignment predicate.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0] MEM_RD_WORD = 4'b1010;
  localparam logic [3:0] MEM_RD_IDLE = 4'b0000;
  localparam logic [2:0] MEM_WR_WORD = 3'b110;
  localparam logic [2:0] MEM_WR_IDLE = 3'b000;

  // True when the low address bits fall outside the natural alignment of the access.
  function automatic logic access_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] offset,
    input logic       is_store
  );
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    bad = 1'b0;
        F3_H:    bad = offset[0];
        default: bad = |offset;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: bad = 1'b0;
        F3_H, F3_HU: bad = offset[0];
        default:     bad = |offset;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: load byte/halfword extraction with extension,
// and merge of a store byte/halfword into a full memory word.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [15:0] store_data,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = mem_word[8*offset +: 8];
    sel_half = offset[1] ? mem_word[31:16] : mem_word[15:0];
    case (funct3)
      F3_B:    load_result = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_result = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_result = {24'h000000, sel_byte};
      F3_HU:   load_result = {16'h0000, sel_half};
      default: load_result = mem_word;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;

      // Halfword stores feed even lanes from the low byte, odd lanes from the high byte.
      assign lane_src = (funct3 == F3_H) ? store_data[8*(gi%2) +: 8] : store_data[7:0];

      always_comb begin
        case (funct3)
          F3_B:    lane_hit = (offset == 2'(gi));
          F3_H:    lane_hit = (offset[1] == 1'(gi / 2));
          default: lane_hit = 1'b1;
        endcase
      end

      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : mem_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-organised data memory, with RMW for SB/SH.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned LW/SW/LH/LHU/SH accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_storedata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic [3:0]            mem_read,
  output logic [2:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  lsu_state_t            state_reg, state_next;
  logic [2:0]            funct3_reg, funct3_next;
  logic [1:0]            offset_reg, offset_next;
  logic                  rmw_reg, rmw_next;
  logic [15:0]           store_lo_reg, store_lo_next;
  logic [3:0]            mem_read_reg, mem_read_next;
  logic [2:0]            mem_write_reg, mem_write_next;
  logic [ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
  logic [DATA_WIDTH-1:0] mem_writedata_reg, mem_writedata_next;
  logic [DATA_WIDTH-1:0] load_data_reg, load_data_next;
  logic                  load_valid_reg, load_valid_next;

  logic        req_legal;
  logic        req_misaligned;
  logic        req_accept;
  logic        store_is_word;
  logic [31:0] align_load;
  logic [31:0] align_merged;

  assign req_legal     = req_valid && (req_load ^ req_store);
  assign store_is_word = (req_funct3 != F3_B) && (req_funct3 != F3_H);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = !reset && req_legal && (state_reg == ST_IDLE) &&
                          access_misaligned(req_funct3, req_address[1:0], req_store);
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_accept = !reset && (state_reg == ST_IDLE) && req_legal && !req_misaligned;
  assign stall      = req_accept || (state_reg == ST_RD) || (state_reg == ST_WR);
  assign misaligned = req_misaligned;

  lsu_data_align u_align (
    .funct3      (funct3_reg),
    .offset      (offset_reg),
    .mem_word    (mem_readdata),
    .store_data  (store_lo_reg),
    .load_result (align_load),
    .merged_word (align_merged)
  );

  always_comb begin
    state_next         = state_reg;
    funct3_next        = funct3_reg;
    offset_next        = offset_reg;
    rmw_next           = rmw_reg;
    store_lo_next      = store_lo_reg;
    mem_read_next      = mem_read_reg;
    mem_write_next     = mem_write_reg;
    mem_address_next   = mem_address_reg;
    mem_writedata_next = mem_writedata_reg;
    load_data_next     = load_data_reg;
    load_valid_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_accept) begin
          funct3_next      = req_funct3;
          offset_next      = req_address[1:0];
          store_lo_next    = req_storedata[15:0];
          mem_address_next = {req_address[ADDR_WIDTH-1:2], 2'b00};
          if (req_load) begin
            rmw_next      = 1'b0;
            mem_read_next = MEM_RD_WORD;
            state_next    = ST_RD;
          end else if (store_is_word) begin
            rmw_next           = 1'b0;
            mem_write_next     = MEM_WR_WORD;
            mem_writedata_next = req_storedata;
            state_next         = ST_WR;
          end else begin
            // Sub-word store: fetch the enclosing word first, merge, then write it back.
            rmw_next      = 1'b1;
            mem_read_next = MEM_RD_WORD;
            state_next    = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (!mem_busywait) begin
          mem_read_next = MEM_RD_IDLE;
          if (rmw_reg) begin
            mem_write_next     = MEM_WR_WORD;
            mem_writedata_next = align_merged;
            state_next         = ST_WR;
          end else begin
            load_data_next  = align_load;
            load_valid_next = 1'b1;
            state_next      = ST_DONE;
          end
        end
      end

      ST_WR: begin
        if (!mem_busywait) begin
          mem_write_next = MEM_WR_IDLE;
          state_next     = ST_DONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      funct3_reg        <= 3'b000;
      offset_reg        <= 2'b00;
      rmw_reg           <= 1'b0;
      store_lo_reg      <= 16'h0000;
      mem_read_reg      <= MEM_RD_IDLE;
      mem_write_reg     <= MEM_WR_IDLE;
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
      load_data_reg     <= '0;
      load_valid_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      funct3_reg        <= funct3_next;
      offset_reg        <= offset_next;
      rmw_reg           <= rmw_next;
      store_lo_reg      <= store_lo_next;
      mem_read_reg      <= mem_read_next;
      mem_write_reg     <= mem_write_next;
      mem_address_reg   <= mem_address_next;
      mem_writedata_reg <= mem_writedata_next;
      load_data_reg     <= load_data_next;
      load_valid_reg    <= load_valid_next;
    end
  end

  assign mem_read      = mem_read_reg;
  assign mem_write     = mem_write_reg;
  assign mem_address   = mem_address_reg;
  assign mem_writedata = mem_writedata_reg;
  assign load_data     = load_data_reg;
  assign load_valid    = load_valid_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small word memory model with
// programmable busywait; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_storedata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  logic [31:0] mem_model [0:63];
  logic [31:0] load_q [$];
  logic [63:0] wr_q [$];
  int          busy_rd;
  int          busy_wr;
  logic [31:0] cur_addr;
  int          n_checks;
  int          n_errors;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_load      (req_load),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_address   (req_address),
    .req_storedata (req_storedata),
    .stall         (stall),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .misaligned    (misaligned),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: busywait and read data settle just after each posedge.
  initial begin
    mem_busywait = 1'b0;
    mem_readdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_read[3] && busy_rd > 0) begin
        mem_busywait = 1'b1;
        busy_rd--;
      end else if (mem_write[2] && busy_wr > 0) begin
        mem_busywait = 1'b1;
        busy_wr--;
      end else begin
        mem_busywait = 1'b0;
      end
      mem_readdata = mem_model[mem_address[7:2]];
    end
  end

  // Output monitor: pops the scoreboard and commits writes that complete this cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (load_valid === 1'b1) begin
        if (load_q.size() == 0) check("load_expected", 64'(load_q.size() != 0), 64'd1);
        else check("load_data", 64'(load_data), 64'(load_q.pop_front()));
      end
      if (mem_write[2] === 1'b1) begin
        check("rw_exclusive", 64'(mem_read[3]), 64'd0);
        if (mem_busywait === 1'b0) begin
          if (wr_q.size() == 0) check("write_expected", 64'(wr_q.size() != 0), 64'd1);
          else check("write_addr_data", {mem_address, mem_writedata}, wr_q.pop_front());
          mem_model[mem_address[7:2]] = mem_writedata;
        end
      end
      if (mem_read[3] === 1'b1 && mem_busywait === 1'b1) begin
        check("busy_hold_cmd", 64'(mem_read), 64'(MEM_RD_WORD));
        check("busy_hold_addr", 64'(mem_address), 64'(cur_addr));
      end
    end
  end

  task automatic do_req(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input int busy_r,
                        input int exp_stall, input bit exp_mis, input logic [31:0] exp_val);
    int   cyc;
    logic mis_seen;
    logic lv_seen;
    @(negedge clock);
    if (ld && !st && !exp_mis) load_q.push_back(exp_val);
    if (st && !ld && !exp_mis) wr_q.push_back({addr[31:2], 2'b00, exp_val});
    busy_rd       = busy_r;
    cur_addr      = {addr[31:2], 2'b00};
    req_valid     = 1'b1;
    req_load      = ld;
    req_store     = st;
    req_funct3    = f3;
    req_address   = addr;
    req_storedata = data;
    #1;
    mis_seen = misaligned;
    cyc = 0;
    while (stall === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clock);
      #1;
    end
    lv_seen   = load_valid;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
    check({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_stall));
    check({tag, "_load_valid"}, 64'(lv_seen), 64'(ld && !st && !exp_mis));
    check({tag, "_misaligned"}, 64'(mis_seen), 64'(exp_mis));
    $display("txn %s addr=0x%08h data=0x%08h stall_cycles=%0d load_data=0x%08h",
             tag, addr, data, cyc, load_data);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    req_valid = 1'b0;
    req_load = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'b000;
    req_address = 32'h0;
    req_storedata = 32'h0;
    busy_rd = 0;
    busy_wr = 0;
    cur_addr = 32'h0;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
    mem_model[4] = 32'h8899AABB;

    repeat (3) @(negedge clock);
    check("rst_mem_read", 64'(mem_read), 64'(4'b0000));
    check("rst_mem_write", 64'(mem_write), 64'(3'b000));
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_writedata", 64'(mem_writedata), 64'd0);
    check("rst_load_data", 64'(load_data), 64'd0);
    check("rst_load_valid", 64'(load_valid), 64'd0);
    check("rst_misaligned", 64'(misaligned), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;

    do_req("LB_13",  1, 0, F3_B,  32'h13, 32'h0, 0, 2, 0, 32'hFFFFFF88);
    do_req("LBU_12", 1, 0, F3_BU, 32'h12, 32'h0, 0, 2, 0, 32'h00000099);
    do_req("LH_12",  1, 0, F3_H,  32'h12, 32'h0, 0, 2, 0, 32'hFFFF8899);
    do_req("LHU_10", 1, 0, F3_HU, 32'h10, 32'h0, 0, 2, 0, 32'h0000AABB);
    do_req("LW_10",  1, 0, F3_W,  32'h10, 32'h0, 0, 2, 0, 32'h8899AABB);
    do_req("SB_11",  0, 1, F3_B,  32'h11, 32'h12345655, 0, 3, 0, 32'h889955BB);
    do_req("LW_10b", 1, 0, F3_W,  32'h10, 32'h0, 0, 2, 0, 32'h889955BB);
    do_req("LW_busy", 1, 0, F3_W, 32'h10, 32'h0, 3, 5, 0, 32'h889955BB);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("SH_11",  0, 1, F3_H,  32'h11, 32'h0000BEEF, 0, 0, 1, 32'h0);
    do_req("LW_10c", 1, 0, F3_W,  32'h10, 32'h0, 0, 2, 0, 32'h889955BB);
    do_req("SH_12",  0, 1, F3_H,  32'h12, 32'h0000CAFE, 0, 3, 0, 32'hCAFE55BB);
`else
    do_req("SH_11",  0, 1, F3_H,  32'h11, 32'h0000BEEF, 0, 3, 0, 32'h8899BEEF);
    do_req("LW_10c", 1, 0, F3_W,  32'h10, 32'h0, 0, 2, 0, 32'h8899BEEF);
    do_req("SH_12",  0, 1, F3_H,  32'h12, 32'h0000CAFE, 0, 3, 0, 32'hCAFEBEEF);
`endif
    do_req("LB_12",  1, 0, F3_B,  32'h12, 32'h0, 0, 2, 0, 32'hFFFFFFFE);
    do_req("LHU_12", 1, 0, F3_HU, 32'h12, 32'h0, 0, 2, 0, 32'h0000CAFE);
    do_req("SW_20",  0, 1, F3_W,  32'h20, 32'hCAFEF00D, 0, 2, 0, 32'hCAFEF00D);
    do_req("L110_20", 1, 0, 3'b110, 32'h20, 32'h0, 0, 2, 0, 32'hCAFEF00D);
    do_req("ILLEGAL", 1, 1, F3_W, 32'h10, 32'h0, 0, 0, 0, 32'h0);
    do_req("SB_23_busy", 0, 1, F3_B, 32'h23, 32'h00000077, 2, 5, 0, 32'h77FEF00D);
    do_req("LBU_23", 1, 0, F3_BU, 32'h23, 32'h0, 0, 2, 0, 32'h00000077);

    // Abort an SB while its write-back is held off by busywait.
    @(negedge clock);
    busy_wr       = 20;
    req_valid     = 1'b1;
    req_load      = 1'b0;
    req_store     = 1'b1;
    req_funct3    = F3_B;
    req_address   = 32'h21;
    req_storedata = 32'h000000AA;
    cnt = 0;
    while (mem_write[2] !== 1'b1 && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("abort_in_wr", 64'(mem_write), 64'(MEM_WR_WORD));
    check("abort_merged", 64'(mem_writedata), 64'h77FEAA0D);
    reset     = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    #1;
    check("abort_mem_read", 64'(mem_read), 64'd0);
    check("abort_mem_write", 64'(mem_write), 64'd0);
    check("abort_mem_address", 64'(mem_address), 64'd0);
    check("abort_mem_writedata", 64'(mem_writedata), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    $display("txn ABORT_SB_21 reset during write-back");
    @(negedge clock);
    reset   = 1'b0;
    busy_wr = 0;

    do_req("LW_20_post", 1, 0, F3_W, 32'h20, 32'h0, 0, 2, 0, 32'h77FEF00D);

    repeat (2) @(negedge clock);
    check("load_q_drained", 64'(load_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
